// File: rtl/pe_accum_stream_if.sv
// pe_accum_stream_if: window input stream and result AXI4-Stream bundle for pe_accum_stream
// Ports: window_flat/valid/ready carry 3x3 windows into the PE; m_axis_* carry requantized results out.
// The slave modport is the PE side and the master modport is the producer/consumer side.
interface pe_accum_stream_if #(
  parameter int PIXEL_WIDTH = 16,
  parameter int OUT_WIDTH   = 16
);
  logic [9*PIXEL_WIDTH-1:0] window_flat;
  logic                     window_valid;
  logic                     window_ready;
  logic [OUT_WIDTH-1:0]     m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;
  modport master (
    output window_flat, window_valid, m_axis_tready,
    input  window_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
  modport slave (
    input  window_flat, window_valid, m_axis_tready,
    output window_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/pe_accum_stream.sv
// pe_accum_stream: 3x3 conv PE accumulating partial sums across channels in RAM, requantized to AXI4-Stream
// Ports: clk/rst (sync, active-high); start + cfg_* launch a map; kernel_load latches kernel_flat/bias
// for the next channel; s.window_* is the window input stream, s.m_axis_* the result stream;
// busy spans start to final beat, done pulses after the final tlast handshake.
module pe_accum_stream #(
  parameter int PIXEL_WIDTH  = 16,
  parameter int KERNEL_WIDTH = 16,
  parameter int ACC_WIDTH    = 48,
  parameter int OUT_WIDTH    = 16,
  parameter int MAP_PIXELS   = 16384,
  parameter int ADDR_WIDTH   = $clog2(MAP_PIXELS),
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [7:0]                    cfg_num_ch,
  input  logic [5:0]                    cfg_shift,
  input  logic                          cfg_relu,
  input  logic                          kernel_load,
  input  logic [9*KERNEL_WIDTH-1:0]     kernel_flat,
  input  logic signed [ACC_WIDTH-1:0]   bias,
  pe_accum_stream_if.slave              s,
  output logic                          busy,
  output logic                          done
);
  localparam int PW = PIXEL_WIDTH + KERNEL_WIDTH;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC_WIDTH-1:0] OMAX = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OMIN = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, WAIT_KERNEL, STREAM, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] num_ch_q, num_ch_d, ch_q, ch_d;
  logic [5:0] shift_q, shift_d;
  logic relu_q, relu_d, done_q, done_d;
  logic [9*KERNEL_WIDTH-1:0] kern_q, kern_d;
  logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
  logic [ADDR_WIDTH-1:0] pix_q, pix_d, a1_q, a2_q, a3_q;
  logic v1_q, v2_q, v3_q, f1_q, f2_q, l1_q, l2_q, l3_q;
  logic signed [PW-1:0] p1_q [9];
  logic signed [PW-1:0] p1_d [9];
  logic signed [ACC_WIDTH-1:0] sum2_q, sum2_d, r2_q, acc3_q, acc3_d, sh, rl;
  logic [OUT_WIDTH-1:0] q;
  logic [OUT_WIDTH:0] fmem [FIFO_DEPTH];
  logic [FW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FW:0] cnt_q, cnt_d;
  logic last_ch, accept, chan_end, push, pop;
  logic signed [ACC_WIDTH-1:0] ram [MAP_PIXELS];
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign s.m_axis_tvalid = cnt_q != '0;
  assign {s.m_axis_tlast, s.m_axis_tdata} = cnt_q != '0 ? fmem[rd_q] : '0;
  always_comb begin
    last_ch = ch_q == num_ch_q - 8'd1;
    // On the last channel every in-flight beat will land in the FIFO, so reserve room for it up front.
    s.window_ready = state_q == STREAM &&
      (!last_ch || 32'(cnt_q) + 32'(v1_q) + 32'(v2_q) + 32'(v3_q) < FIFO_DEPTH);
    accept = s.window_valid && s.window_ready;
    chan_end = accept && pix_q == ADDR_WIDTH'(MAP_PIXELS - 1);
    push = v3_q && l3_q;
    pop = s.m_axis_tvalid && s.m_axis_tready;
    state_d = state_q;
    num_ch_d = num_ch_q;
    shift_d = shift_q;
    relu_d = relu_q;
    ch_d = ch_q;
    pix_d = pix_q;
    kern_d = kern_q;
    bias_d = bias_q;
    if (state_q == IDLE && start) begin
      state_d = WAIT_KERNEL;
      num_ch_d = cfg_num_ch == 8'd0 ? 8'd1 : cfg_num_ch;
      shift_d = cfg_shift;
      relu_d = cfg_relu;
      ch_d = '0;
      pix_d = '0;
    end
    if (state_q == WAIT_KERNEL && kernel_load) begin
      state_d = STREAM;
      kern_d = kernel_flat;
      bias_d = bias;
    end
    if (accept) pix_d = chan_end ? '0 : pix_q + ADDR_WIDTH'(1);
    if (chan_end) begin
      state_d = last_ch ? DRAIN : WAIT_KERNEL;
      ch_d = ch_q + 8'd1;
    end
    done_d = state_q == DRAIN && pop && s.m_axis_tlast;
    if (done_d) state_d = IDLE;
    for (int i = 0; i < 9; i++)
      p1_d[i] = $signed(s.window_flat[i*PIXEL_WIDTH +: PIXEL_WIDTH]) * $signed(kern_q[i*KERNEL_WIDTH +: KERNEL_WIDTH]);
    sum2_d = '0;
    for (int i = 0; i < 9; i++) sum2_d = sum2_d + ACC_WIDTH'(p1_q[i]);
    acc3_d = (f2_q ? '0 : r2_q) + sum2_q + (l2_q ? bias_q : '0);
    sh = acc3_q >>> shift_q;
    rl = relu_q && sh[ACC_WIDTH-1] ? '0 : sh;
    q = rl > OMAX ? OMAX[OUT_WIDTH-1:0] : rl < OMIN ? OMIN[OUT_WIDTH-1:0] : rl[OUT_WIDTH-1:0];
    wr_d = push ? (wr_q == FW'(FIFO_DEPTH - 1) ? '0 : wr_q + FW'(1)) : wr_q;
    rd_d = pop ? (rd_q == FW'(FIFO_DEPTH - 1) ? '0 : rd_q + FW'(1)) : rd_q;
    cnt_d = cnt_q + (FW+1)'(push) - (FW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_ch_q <= 8'd1;
      shift_q <= '0;
      relu_q <= 1'b0;
      ch_q <= '0;
      pix_q <= '0;
      kern_q <= '0;
      bias_q <= '0;
      done_q <= 1'b0;
      {v1_q, v2_q, v3_q} <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      num_ch_q <= num_ch_d;
      shift_q <= shift_d;
      relu_q <= relu_d;
      ch_q <= ch_d;
      pix_q <= pix_d;
      kern_q <= kern_d;
      bias_q <= bias_d;
      done_q <= done_d;
      {v1_q, v2_q, v3_q} <= {accept, v1_q, v2_q};
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // Datapath and storage carry no reset: valids gate every use, and channel 0 overwrites the RAM.
  always_ff @(posedge clk) begin
    p1_q <= p1_d;
    {a1_q, f1_q, l1_q} <= {pix_q, ch_q == 8'd0, last_ch};
    {a2_q, f2_q, l2_q} <= {a1_q, f1_q, l1_q};
    {a3_q, l3_q} <= {a2_q, l2_q};
    sum2_q <= sum2_d;
    r2_q <= ram[a1_q];
    acc3_q <= acc3_d;
    if (v3_q) ram[a3_q] <= acc3_q;
    if (push) fmem[wr_q] <= {a3_q == ADDR_WIDTH'(MAP_PIXELS - 1), q};
  end
endmodule
